svfloat_mul_stream: RTL and testbench
=====================================

Name: svfloat_mul_stream

Overview:
- Valid/ready streaming front-end that feeds operand pairs into an internal svfloat_mul instance and buffers its products for a downstream consumer.
- svfloat_mul has no enable or stall, so this block tracks the in-flight operations itself and uses an output FIFO with credit accounting. Backpressure therefore never drops a result.
- Sits between an operand producer (register file / issue logic) and any result consumer (accumulator, writeback).
- An optional tag travels with each operation, so results can be matched back to their requests.

Parameters:
- float, svfloat::float32, floating-point type passed unchanged to svfloat_mul.
- plr_pre_mul, 0, forwarded to svfloat_mul: pipeline register before the multiplier.
- plr_post_mul, 0, forwarded to svfloat_mul: pipeline register after the multiplier.
- TAG_W, 4, width of the user tag carried with each operation (≥1).
- DEPTH, 4, output FIFO entries.
  - Elaboration error if DEPTH < L+2, where L = plr_pre_mul + plr_post_mul.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and tag are valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_lhs  in  $bits(float)  left-hand operand.
- in_rhs  in  $bits(float)  right-hand operand.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  out_res and out_tag hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_res  out  $bits(float)  product from svfloat_mul.
- out_tag  out  TAG_W  tag of that product.

Behaviour:
- Handshake events:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- Reset: on a clock edge with rst=1, all of the following clear, including any operation in flight:
  - valid/tag shift register (depth L);
  - FIFO pointers and count;
  - occupancy counter.
- Outputs during and after reset:
  - While rst=1: in_ready=0 and out_valid=0.
  - First cycle after rst deasserts: in_ready=1, out_valid=0.
  - out_res and out_tag are don't-care while out_valid=0.
- Datapath:
  - in_lhs and in_rhs drive svfloat_mul directly.
  - A parallel shift register of L stages carries {valid, tag}. It advances every cycle and is never stalled.
  - When its output bit is valid, {mul res, tag} is written into the FIFO.
  - With L=0 the write happens in the accept cycle.
- Latency:
  - Accept in cycle N → out_valid in cycle N+L+1, provided earlier results have drained.
  - No FIFO bypass.
  - Results leave in strict acceptance order.
- Credit accounting:
  - occ = in-flight ops + FIFO count, width clog2(DEPTH+1).
  - occ increments on accept and decrements on pop; simultaneous accept and pop leaves occ unchanged.
  - in_ready = !rst && occ < DEPTH. This uses registered occ only, so there is no combinational path from out_ready to in_ready.
  - The FIFO therefore never overflows; an overflow write is an assertion failure.
- Throughput: 1 op/cycle sustained while out_ready=1, guaranteed by DEPTH ≥ L+2.
- FIFO:
  - Registered read port; out_valid = count≠0.
  - out_res and out_tag are stable while out_valid=1 && out_ready=0.
  - Push and pop in the same cycle are both performed.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Input side:
  - in_lhs, in_rhs and in_tag are ignored when no accept occurs.
  - in_valid may drop without an accept (no stability requirement upstream).
- Reset mid-operation: in-flight and buffered results are discarded; nothing is emitted after reset for pre-reset accepts.

Test Plan:
- L=0, DEPTH=4, single op: lhs 0x40000000 (2.0), rhs 0x40400000 (3.0), tag 5 → out_valid 1 cycle later, out_res 0x40C00000, out_tag 5.
- plr_pre_mul=1, plr_post_mul=1, DEPTH=4, out_ready=1: 8 back-to-back ops (1.5×-4.0 = 0xC0C00000 among them), tags 0..7 → in_ready stays 1, results arrive in order starting 3 cycles after the first accept, 1 per cycle.
- L=2, DEPTH=4, out_ready=0: stream ops → exactly 4 accepted, then in_ready=0. Release out_ready → 4 results in order, in_ready returns 1 cycle after the first pop. No loss.
- Simultaneous accept and pop with occ=DEPTH-1 → occ unchanged, in_ready stays 1, output data stable under stall cycles.
- Assert rst for 1 cycle with 2 ops in flight and 2 in the FIFO → out_valid=0 next cycle, in_ready=1 after release, no stale results ever appear.
- Random valid/ready for 10k ops with a scoreboard against svfloat_mul products and tags → no mismatch, order preserved.

Source files
------------

// File: rtl/svfloat_mul_stream.sv
// Valid/ready streaming wrapper around the stall-free svfloat_mul multiplier.
// Occupancy credits reserve an output FIFO slot per accepted op, so backpressure never drops a product.

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

// Single-precision multiplier, round-to-nearest-even, subnormals flushed to zero.
module svfloat_mul #(
  parameter type float        = svfloat::float32,
  parameter int  plr_pre_mul  = 0,
  parameter int  plr_post_mul = 0
) (
  input  logic                    clk,
  input  logic [$bits(float)-1:0] lhs,
  input  logic [$bits(float)-1:0] rhs,
  output logic [$bits(float)-1:0] res
);
  logic [31:0]       w_a, w_b, w_p;
  logic              w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [47:0]       w_prod;
  logic [22:0]       w_frac;
  logic              w_guard, w_sticky;
  logic [23:0]       w_frac_rnd;
  logic signed [9:0] w_exp, w_exp_rnd;

  if ($bits(float) != 32) begin : g_bad_float
    $error("svfloat_mul supports 32-bit floats only");
  end

  if (plr_pre_mul != 0) begin : g_pre
    logic [31:0] r_a, r_b;
    always_ff @(posedge clk) begin
      r_a <= lhs;
      r_b <= rhs;
    end
    assign w_a = r_a;
    assign w_b = r_b;
  end else begin : g_no_pre
    assign w_a = lhs;
    assign w_b = rhs;
  end

  always_comb begin
    w_sign   = w_a[31] ^ w_b[31];
    w_a_zero = (w_a[30:23] == 8'd0);
    w_b_zero = (w_b[30:23] == 8'd0);
    w_a_inf  = (&w_a[30:23]) && (w_a[22:0] == 23'd0);
    w_b_inf  = (&w_b[30:23]) && (w_b[22:0] == 23'd0);
    w_a_nan  = (&w_a[30:23]) && (|w_a[22:0]);
    w_b_nan  = (&w_b[30:23]) && (|w_b[22:0]);
    w_prod   = 48'({1'b1, w_a[22:0]}) * 48'({1'b1, w_b[22:0]});
    // Product of two [1,2) significands lies in [1,4): bit 47 selects the normalisation shift.
    if (w_prod[47]) begin
      w_frac   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
    end else begin
      w_frac   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_frac_rnd = {1'b0, w_frac} + 24'(w_guard && (w_sticky || w_frac[0]));
    w_exp      = $signed({2'b00, w_a[30:23]}) + $signed({2'b00, w_b[30:23]})
               - 10'sd127 + $signed({9'd0, w_prod[47]});
    w_exp_rnd  = w_exp + $signed({9'd0, w_frac_rnd[23]});
    w_p        = {w_sign, w_exp_rnd[7:0], w_frac_rnd[22:0]};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_p = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_inf) begin
      w_p = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_p = {w_sign, 31'd0};
    end else if (w_exp_rnd >= 10'sd255) begin
      w_p = {w_sign, 8'hFF, 23'd0};
    end else if (w_exp_rnd <= 10'sd0) begin
      w_p = {w_sign, 31'd0};
    end
  end

  if (plr_post_mul != 0) begin : g_post
    logic [31:0] r_p;
    always_ff @(posedge clk) begin
      r_p <= w_p;
    end
    assign res = r_p;
  end else begin : g_no_post
    assign res = w_p;
  end

  if (plr_pre_mul == 0 && plr_post_mul == 0) begin : g_comb_only
    logic w_unused_clk;
    assign w_unused_clk = clk;
  end
endmodule

module svfloat_mul_stream #(
  parameter type float        = svfloat::float32,
  parameter int  plr_pre_mul  = 0,
  parameter int  plr_post_mul = 0,
  parameter int  TAG_W        = 4,
  parameter int  DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$bits(float)-1:0] in_lhs,
  input  logic [$bits(float)-1:0] in_rhs,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$bits(float)-1:0] out_res,
  output logic [TAG_W-1:0]        out_tag
);
  localparam int L     = plr_pre_mul + plr_post_mul;
  localparam int FW    = $bits(float);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < L + 2) begin : g_bad_depth
    $error("svfloat_mul_stream: DEPTH must be at least pipeline latency + 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("svfloat_mul_stream: TAG_W must be at least 1");
  end

  logic             w_accept, w_pop, w_push;
  logic [TAG_W-1:0] w_push_tag;
  logic [FW-1:0]    w_mul_res;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_inc, w_rd_ptr_inc;
  logic [OCC_W-1:0] r_count, r_occ;
  logic [FW-1:0]    r_mem_res [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];
  logic [FW-1:0]    r_out_res;
  logic [TAG_W-1:0] r_out_tag;

  assign in_ready  = !rst && (r_occ < OCC_W'(DEPTH));
  assign out_valid = !rst && (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_res   = r_out_res;
  assign out_tag   = r_out_tag;

  svfloat_mul #(
    .float       (float),
    .plr_pre_mul (plr_pre_mul),
    .plr_post_mul(plr_post_mul)
  ) u_mul (
    .clk(clk),
    .lhs(in_lhs),
    .rhs(in_rhs),
    .res(w_mul_res)
  );

  // {valid, tag} travels alongside the multiplier pipeline and is never stalled.
  if (L == 0) begin : g_no_sr
    assign w_push     = w_accept;
    assign w_push_tag = in_tag;
  end else begin : g_sr
    logic [L-1:0]     r_sr_valid;
    logic [TAG_W-1:0] r_sr_tag [L];
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sr_valid <= '0;
      end else begin
        r_sr_valid[0] <= w_accept;
        for (int i = 1; i < L; i++) begin
          r_sr_valid[i] <= r_sr_valid[i-1];
        end
      end
      r_sr_tag[0] <= in_tag;
      for (int i = 1; i < L; i++) begin
        r_sr_tag[i] <= r_sr_tag[i-1];
      end
    end
    assign w_push     = r_sr_valid[L-1];
    assign w_push_tag = r_sr_tag[L-1];
  end

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_res[r_wr_ptr] <= w_mul_res;
      r_mem_tag[r_wr_ptr] <= w_push_tag;
    end
  end

  // Output register holds the head entry; it loads the incoming product when the FIFO would otherwise be empty.
  always_ff @(posedge clk) begin
    if (w_push && ((r_count - OCC_W'(w_pop)) == '0)) begin
      r_out_res <= w_mul_res;
      r_out_tag <= w_push_tag;
    end else if (w_pop) begin
      r_out_res <= r_mem_res[w_rd_ptr_inc];
      r_out_tag <= r_mem_tag[w_rd_ptr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == OCC_W'(DEPTH))));
endmodule

// File: tb/tb_svfloat_mul_stream.sv
// Bench for svfloat_mul_stream: a combinational (L=0) and a two-stage (L=2) instance checked
// every cycle against a queue model whose products come from real arithmetic.
module tb_svfloat_mul_stream;
  localparam int NOPS = 10000;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s_iv [2];
  logic        s_ir [2];
  logic        s_ov [2];
  logic        s_ordy [2];
  logic [31:0] s_lhs [2];
  logic [31:0] s_rhs [2];
  logic [31:0] s_res [2];
  logic [3:0]  s_itag [2];
  logic [3:0]  s_otag [2];

  // Operands with short significands so every product is exact in single precision.
  logic [31:0] vals [16] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
                             32'hC0800000, 32'h3F400000, 32'h3FA00000, 32'hC0200000,
                             32'h40A00000, 32'h3F000000, 32'hC0E00000, 32'h00000000,
                             32'h41200000, 32'hBEC00000, 32'h42C80000, 32'h3FE00000};

  function automatic real f2r(input logic [31:0] a);
    real r;
    if (a[30:23] == 8'd0) begin
      r = 0.0;
      if (a[31]) r = -r;
    end else begin
      r = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
    end
    return r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = 2 * gi + 1;
    exp_t q[$];

    svfloat_mul_stream #(
      .plr_pre_mul (gi),
      .plr_post_mul(gi),
      .TAG_W       (4),
      .DEPTH       (4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s_iv[gi]),
      .in_ready (s_ir[gi]),
      .in_lhs   (s_lhs[gi]),
      .in_rhs   (s_rhs[gi]),
      .in_tag   (s_itag[gi]),
      .out_valid(s_ov[gi]),
      .out_ready(s_ordy[gi]),
      .out_res  (s_res[gi]),
      .out_tag  (s_otag[gi])
    );

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("rst_in_ready_l%0d", 2 * gi), 32'(s_ir[gi]), 32'd0);
        chk($sformatf("rst_out_valid_l%0d", 2 * gi), 32'(s_ov[gi]), 32'd0);
        q.delete();
      end else begin
        logic exp_ov;
        exp_ov = 1'b0;
        if (q.size() != 0) exp_ov = (q[0].due <= cyc);
        chk($sformatf("in_ready_l%0d", 2 * gi), 32'(s_ir[gi]), 32'(q.size() < 4));
        chk($sformatf("out_valid_l%0d", 2 * gi), 32'(s_ov[gi]), 32'(exp_ov));
        if (exp_ov && s_ov[gi]) begin
          chk($sformatf("out_res_l%0d", 2 * gi), s_res[gi], q[0].res);
          chk($sformatf("out_tag_l%0d", 2 * gi), 32'(s_otag[gi]), 32'(q[0].tag));
        end
        if (s_ov[gi] && s_ordy[gi] && q.size() != 0) void'(q.pop_front());
        if (s_iv[gi] && s_ir[gi])
          q.push_back('{fmul_model(s_lhs[gi], s_rhs[gi]), s_itag[gi], cyc + LAT});
      end
    end
  end

  initial begin
    int          first_acc, first_out, last_out, n_out, n_acc, n_seen;
    int          acc [2];
    logic [3:0]  got_tag [8];
    logic [31:0] got_res [8];

    for (int i = 0; i < 2; i++) begin
      s_iv[i] = 1'b0; s_ordy[i] = 1'b0; s_lhs[i] = '0; s_rhs[i] = '0; s_itag[i] = '0;
    end

    chk("model_2x3", fmul_model(32'h40000000, 32'h40400000), 32'h40C00000);
    chk("model_1p5xm4", fmul_model(32'h3FC00000, 32'hC0800000), 32'hC0C00000);
    chk("model_0p5x0p75", fmul_model(32'h3F000000, 32'h3F400000), 32'h3EC00000);
    chk("model_10x10", fmul_model(32'h41200000, 32'h41200000), 32'h42C80000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(s_ir[1]), 32'd1);
    chk("post_rst_out_valid", 32'(s_ov[1]), 32'd0);

    // L=0 single op: 2.0 * 3.0, tag 5
    @(posedge clk); #1;
    s_ordy[0] = 1'b1; s_iv[0] = 1'b1;
    s_lhs[0] = 32'h40000000; s_rhs[0] = 32'h40400000; s_itag[0] = 4'd5;
    @(posedge clk); #1;
    s_iv[0] = 1'b0;
    @(negedge clk);
    chk("l0_single_valid", 32'(s_ov[0]), 32'd1);
    chk("l0_single_res", s_res[0], 32'h40C00000);
    chk("l0_single_tag", 32'(s_otag[0]), 32'd5);
    repeat (2) @(posedge clk);

    // L=2 back-to-back with out_ready held high
    s_ordy[1] = 1'b1;
    first_acc = -1; first_out = -1; last_out = -1; n_out = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          s_iv[1] = 1'b1; s_lhs[1] = vals[(k + 15) % 16]; s_rhs[1] = vals[(k + 2) % 16];
          s_itag[1] = 4'(k);
        end
        @(posedge clk); #1;
        s_iv[1] = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (s_iv[1] && s_ir[1] && first_acc < 0) first_acc = cyc;
          if (s_ov[1] && s_ordy[1]) begin
            if (n_out == 0) first_out = cyc;
            if (n_out < 8) begin
              got_tag[n_out] = s_otag[1];
              got_res[n_out] = s_res[1];
            end
            n_out++;
            last_out = cyc;
          end
        end
      end
    join
    chk("b2b_count", 32'(n_out), 32'd8);
    chk("b2b_latency", 32'(first_out - first_acc), 32'd3);
    chk("b2b_rate", 32'(last_out - first_out), 32'd7);
    chk("b2b_res2", got_res[2], 32'hC0C00000);
    for (int k = 0; k < 8; k++) chk($sformatf("b2b_tag%0d", k), 32'(got_tag[k]), 32'(k));

    // L=2 with out_ready low: only DEPTH ops may be accepted
    s_ordy[1] = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      s_iv[1] = 1'b1; s_lhs[1] = vals[c]; s_rhs[1] = vals[15 - c]; s_itag[1] = 4'(c + 3);
      @(negedge clk);
      if (s_iv[1] && s_ir[1]) n_acc++;
    end
    chk("stall_accepted", 32'(n_acc), 32'd4);
    chk("stall_in_ready", 32'(s_ir[1]), 32'd0);
    @(posedge clk); #1;
    s_iv[1] = 1'b0; s_ordy[1] = 1'b1;
    @(negedge clk);
    chk("release_ready_hold", 32'(s_ir[1]), 32'd0);
    @(negedge clk);
    chk("release_ready_back", 32'(s_ir[1]), 32'd1);
    repeat (6) @(posedge clk);

    // Reset with two ops buffered and two in flight
    s_ordy[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      s_iv[1] = 1'b1; s_lhs[1] = vals[c + 2]; s_rhs[1] = vals[c + 5]; s_itag[1] = 4'(c + 9);
    end
    @(posedge clk); #1;
    s_iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      s_iv[1] = 1'b1; s_lhs[1] = vals[c + 8]; s_rhs[1] = vals[c + 12]; s_itag[1] = 4'(c + 11);
    end
    @(posedge clk); #1;
    s_iv[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(s_ov[1]), 32'd0);
    chk("midrst_in_ready", 32'(s_ir[1]), 32'd1);
    s_ordy[1] = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_ov[1]) n_seen++;
    end
    chk("midrst_no_stale", 32'(n_seen), 32'd0);

    // Random valid/ready on both instances
    acc[0] = 0; acc[1] = 0;
    for (int c = 0; c < 60000 && (acc[0] < NOPS || acc[1] < NOPS); c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        s_iv[i]   = (acc[i] < NOPS) && ($urandom_range(0, 9) < 7);
        s_lhs[i]  = vals[$urandom_range(0, 15)];
        s_rhs[i]  = vals[$urandom_range(0, 15)];
        s_itag[i] = 4'($urandom_range(0, 15));
        s_ordy[i] = ($urandom_range(0, 9) < 6);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (s_iv[i] && s_ir[i]) acc[i]++;
    end
    chk("rand_ops_l0", 32'(acc[0]), 32'(NOPS));
    chk("rand_ops_l2", 32'(acc[1]), 32'(NOPS));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      s_iv[i] = 1'b0; s_ordy[i] = 1'b1;
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drained_l0", 32'(g_dut[0].q.size()), 32'd0);
    chk("drained_l2", 32'(g_dut[1].q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
